// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// opcode values, ALU select encodings and the opcode classification helper.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_STA  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_LDI  = 4'd11;
    localparam logic [3:0] OP_R12  = 4'd12;
    localparam logic [3:0] OP_R13  = 4'd13;
    localparam logic [3:0] OP_R14  = 4'd14;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [2:0] ALU_LDA  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_NOT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_XNOR = 3'b110;
    localparam logic [2:0] ALU_ADD  = 3'b111;

    typedef enum logic [2:0] {
        K_MEMRD, K_MEMWR, K_LDI, K_JMP, K_JZ, K_ILL, K_HLT
    } kind_t;

    // hi_zero is false when a wider opcode has bits set above [3:0].
    function automatic kind_t op_kind(input logic [3:0] op, input logic hi_zero);
        kind_t k;
        k = K_ILL;
        if (hi_zero) begin
            case (op)
                OP_LDA, OP_SUB, OP_AND, OP_OR, OP_NOT,
                OP_XOR, OP_XNOR, OP_ADD: k = K_MEMRD;
                OP_STA:                  k = K_MEMWR;
                OP_LDI:                  k = K_LDI;
                OP_JMP:                  k = K_JMP;
                OP_JZ:                   k = K_JZ;
                OP_HLT:                  k = K_HLT;
                default:                 k = K_ILL;
            endcase
        end
        return k;
    endfunction

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        return (op == OP_ADD) ? ALU_ADD : op[2:0];
    endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// Memory wait counter: counts stalled cycles of one access and flags the cycle
// in which the count would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)   cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute/writeback sequencing with
// memory handshake, timeout error and halt.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           ac_zero,
    input  logic           mem_ready,
    output logic           rd_mem,
    output logic           wr_mem,
    output logic           ld_ir,
    output logic           ld_ac,
    output logic           ac_src,
    output logic           ld_pc,
    output logic           pc_src,
    output logic           jmp_uncond,
    output logic [2:0]     alu_op,
    output logic           halted,
    output logic           err,
    output logic           illegal
);
    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           z_q, z_d;
    logic           err_q, err_d;
    kind_t          kind;
    logic           wait_st, expired;

    // All execute/writeback decoding uses the latched opcode only.
    assign kind    = op_kind(op_q[3:0], (op_q >> 4) == '0);
    assign wait_st = (state_q == S_FETCH) ||
                     (state_q == S_EXEC && (kind == K_MEMRD || kind == K_MEMWR));

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!wait_st),
        .en      (wait_st && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        z_d        = z_q;
        err_d      = err_q;
        rd_mem     = 1'b0;
        wr_mem     = 1'b0;
        ld_ir      = 1'b0;
        ld_ac      = 1'b0;
        ac_src     = 1'b0;
        ld_pc      = 1'b0;
        pc_src     = 1'b0;
        jmp_uncond = 1'b0;
        alu_op     = 3'b000;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                rd_mem = 1'b1;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                op_d    = opcode;
                z_d     = ac_zero;
                state_d = (opcode == OPW'(OP_HLT)) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (kind)
                    K_MEMRD, K_MEMWR: begin
                        rd_mem = (kind == K_MEMRD);
                        wr_mem = (kind == K_MEMWR);
                        if (kind == K_MEMRD) alu_op = alu_sel(op_q[3:0]);
                        if (mem_ready) state_d = S_WB;
                        else if (expired) begin
                            err_d   = 1'b1;
                            state_d = S_HALT;
                        end
                    end
                    K_LDI: state_d = S_WB;
                    K_JMP, K_JZ: begin
                        ld_pc      = 1'b1;
                        pc_src     = (kind == K_JMP) || z_q;
                        jmp_uncond = (kind == K_JMP);
                        state_d    = S_FETCH;
                    end
                    K_ILL: begin
                        illegal = 1'b1;
                        state_d = S_WB;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_WB: begin
                ld_pc   = 1'b1;
                ld_ac   = (kind == K_MEMRD) || (kind == K_LDI);
                ac_src  = (kind == K_LDI);
                if (kind == K_MEMRD) alu_op = alu_sel(op_q[3:0]);
                state_d = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues expected strobe
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst_n, start, ac_zero, mem_ready;
    logic [3:0] opcode;
    logic       rd_mem, wr_mem, ld_ir, ld_ac, ac_src, ld_pc, pc_src, jmp_uncond;
    logic [2:0] alu_op;
    logic       halted, err, illegal;

    int errors = 0;
    int checks = 0;
    logic [13:0] expq[$];
    int lat_rd = 0, lat_wr = 0, acc = 0;
    int pc_cnt = 0, rd_cyc = 0, wr_cyc = 0, ldac_cyc = 0;
    logic halted_prev = 1'b0;

    multicycle_controller #(.OPW(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ac_zero(ac_zero),
        .mem_ready(mem_ready), .rd_mem(rd_mem), .wr_mem(wr_mem), .ld_ir(ld_ir),
        .ld_ac(ld_ac), .ac_src(ac_src), .ld_pc(ld_pc), .pc_src(pc_src),
        .jmp_uncond(jmp_uncond), .alu_op(alu_op), .halted(halted), .err(err),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {rd_mem, wr_mem, ld_ir, ld_ac, ac_src, ld_pc, pc_src,
                       jmp_uncond, alu_op, halted, err, illegal};

    function automatic logic [13:0] ev(bit rd, bit wr, bit ir, bit ac, bit acs, bit pc,
                                       bit pcs, bit j, logic [2:0] alu, bit h, bit e, bit il);
        return {rd, wr, ir, ac, acs, pc, pcs, j, alu, h, e, il};
    endfunction

    // Memory model: ready in the lat-th cycle of an access; lat=0 never ready.
    always @(negedge clk) begin
        if (rd_mem || wr_mem) begin
            acc = acc + 1;
            mem_ready = rd_mem ? (lat_rd != 0 && acc == lat_rd)
                               : (lat_wr != 0 && acc == lat_wr);
        end else begin
            acc = 0;
            mem_ready = 1'b0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            rd_cyc   = rd_cyc + int'(rd_mem);
            wr_cyc   = wr_cyc + int'(wr_mem);
            ldac_cyc = ldac_cyc + int'(ld_ac);
            pc_cnt   = pc_cnt + int'(ld_pc);
            if (ld_ir || ld_ac || ld_pc || illegal || (halted && !halted_prev)) begin
                checks = checks + 1;
                if (expq.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL event: unexpected output %b at %0t", obs, $time);
                end else begin
                    logic [13:0] e;
                    e = expq.pop_front();
                    if (obs !== e) begin
                        errors = errors + 1;
                        $display("FAIL event: got %b expected %b at %0t", obs, e, $time);
                    end
                end
            end
        end
        halted_prev = halted;
    end

    task automatic check(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_pc(input string name, input int snap);
        int n;
        n = 0;
        while (pc_cnt == snap && n < 200) begin
            cyc();
            n++;
        end
        if (pc_cnt == snap) check({name, " timeout"}, 0, 1);
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 200) begin
            cyc();
            n++;
        end
        if (!halted) check({name, " halt timeout"}, 0, 1);
    endtask

    task automatic run_instr(input string name, input logic [3:0] op, input bit acz,
                             input int lr, input int lw, input logic [2:0] alu,
                             input int rd_e, input int wr_e, input int ac_e);
        int snap, r0, w0, a0;
        snap = pc_cnt; r0 = rd_cyc; w0 = wr_cyc; a0 = ldac_cyc;
        opcode = op; ac_zero = acz; lat_rd = lr; lat_wr = lw;
        expq.push_back(ev(1,0,1,0,0,0,0,0,3'b000,0,0,0));
        case (op)
            4'd7:  expq.push_back(ev(0,0,0,0,0,1,1,1,3'b000,0,0,0));
            4'd10: expq.push_back(ev(0,0,0,0,0,1,acz,0,3'b000,0,0,0));
            4'd9:  expq.push_back(ev(0,0,0,0,0,1,0,0,3'b000,0,0,0));
            4'd11: expq.push_back(ev(0,0,0,1,1,1,0,0,3'b000,0,0,0));
            4'd12, 4'd13, 4'd14: begin
                expq.push_back(ev(0,0,0,0,0,0,0,0,3'b000,0,0,1));
                expq.push_back(ev(0,0,0,0,0,1,0,0,3'b000,0,0,0));
            end
            default: expq.push_back(ev(0,0,0,1,0,1,0,0,alu,0,0,0));
        endcase
        wait_pc(name, snap);
        check({name, " rd cycles"}, rd_cyc - r0, rd_e);
        check({name, " wr cycles"}, wr_cyc - w0, wr_e);
        check({name, " ld_ac cycles"}, ldac_cyc - a0, ac_e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; start = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int bad, w0, r0;
        rst_n = 1'b0; start = 1'b0; opcode = 4'd0; ac_zero = 1'b0; mem_ready = 1'b0;
        #3;
        check("reset outputs", int'(obs), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        check("idle without start", int'(obs), 0);
        start = 1'b1;
        run_instr("LDA",   4'd0,  0, 3, 0, 3'b000, 6, 0, 1);
        run_instr("ADD",   4'd8,  0, 1, 0, 3'b111, 2, 0, 1);
        run_instr("SUB",   4'd1,  0, 2, 0, 3'b001, 4, 0, 1);
        run_instr("XNOR",  4'd6,  0, 1, 0, 3'b110, 2, 0, 1);
        run_instr("STA",   4'd9,  0, 2, 2, 3'b000, 2, 2, 0);
        run_instr("LDI",   4'd11, 0, 1, 0, 3'b000, 1, 0, 1);
        run_instr("JMP",   4'd7,  0, 1, 0, 3'b000, 1, 0, 0);
        run_instr("JZ1",   4'd10, 1, 1, 0, 3'b000, 1, 0, 0);
        run_instr("JZ0",   4'd10, 0, 1, 0, 3'b000, 1, 0, 0);
        run_instr("ILL13", 4'd13, 0, 2, 0, 3'b000, 2, 0, 0);
        run_instr("LAT15", 4'd0,  0, 15, 0, 3'b000, 30, 0, 1);
        check("no err after lat15", int'(err), 0);

        // Fetch never acknowledged: request held 15 cycles, then error halt.
        r0 = rd_cyc; lat_rd = 0;
        expq.push_back(ev(0,0,0,0,0,0,0,0,3'b000,1,1,0));
        wait_halt("timeout");
        check("timeout rd cycles", rd_cyc - r0, 15);

        // HLT: halted persists with start toggling, no strobes.
        do_reset();
        check("err cleared by reset", int'(err), 0);
        start = 1'b1; opcode = 4'd15; lat_rd = 2;
        expq.push_back(ev(1,0,1,0,0,0,0,0,3'b000,0,0,0));
        expq.push_back(ev(0,0,0,0,0,0,0,0,3'b000,1,0,0));
        wait_halt("HLT");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            start = ~start;
            cyc();
            if (obs !== ev(0,0,0,0,0,0,0,0,3'b000,1,0,0)) bad++;
        end
        check("HLT hold bad cycles", bad, 0);

        // Reset in the middle of a stalled STA write.
        do_reset();
        start = 1'b1; opcode = 4'd9; lat_rd = 1; lat_wr = 0;
        expq.push_back(ev(1,0,1,0,0,0,0,0,3'b000,0,0,0));
        w0 = 0;
        while (!wr_mem && w0 < 50) begin
            cyc();
            w0++;
        end
        check("STA reached write", int'(wr_mem), 1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset mid-write", int'(obs), 0);
        cyc();
        start = 1'b0; rst_n = 1'b1;
        repeat (4) cyc();
        check("idle after release", int'(obs), 0);

        check("scoreboard drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter OPW, default 4; opcode width, SHALL be ≥4.
REQ-002 Parameter TIMEOUT, default 15; maximum mem_ready wait cycles, SHALL be ≥1.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  leaves IDLE when high.
REQ-006 opcode  in  OPW  instruction opcode from IR; sampled only in DECODE.
REQ-007 ac_zero  in  1  accumulator equals zero; sampled only in DECODE.
REQ-008 mem_ready  in  1  memory completes current rd_mem/wr_mem access this cycle.
REQ-009 rd_mem, wr_mem  out  1 each  memory read / write request.
REQ-010 ld_ir  out  1  load instruction register.
REQ-011 ld_ac  out  1  load accumulator.
REQ-012 ac_src  out  1  accumulator source: 0 = ALU, 1 = immediate.
REQ-013 ld_pc  out  1  load PC.
REQ-014 pc_src  out  1  PC source: 0 = PC+1, 1 = jump target.
REQ-015 jmp_uncond  out  1  unconditional jump taken.
REQ-016 alu_op  out  3  ALU operation select.
REQ-017 halted  out  1  controller in HALT.
REQ-018 err  out  1  sticky timeout-error flag.
REQ-019 illegal  out  1  one-cycle pulse on undefined opcode.

Function
REQ-020 States SHALL be IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-021 IDLE -> FETCH when start=1; otherwise remain; all outputs 0.
REQ-022 FETCH: rd_mem=1 until mem_ready; in the mem_ready cycle ld_ir=1, next state DECODE.
REQ-023 DECODE: one cycle, no strobes; latches opcode and ac_zero; next state EXEC, or HALT for opcode 15.
REQ-024 Opcodes: 0 LDA, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 XNOR, 8 ADD: alu_op = opcode[2:0] (ADD = 3'b111); EXEC rd_mem=1 until mem_ready, then WB.
REQ-025 Opcode 9 STA: EXEC wr_mem=1 until mem_ready, then WB with ld_ac=0.
REQ-026 Opcode 11 LDI: EXEC one cycle, no memory access; WB ac_src=1.
REQ-027 WB: one cycle; ld_ac=1 except STA; ld_pc=1, pc_src=0; next state FETCH.
REQ-028 Opcode 7 JMP: EXEC one cycle with ld_pc=1, pc_src=1, jmp_uncond=1; next state FETCH.
REQ-029 Opcode 10 JZ: if latched ac_zero=1, behaves as JMP but jmp_uncond=0; otherwise EXEC ld_pc=1, pc_src=0.
REQ-030 Opcodes 12-14 (and all values >15 when OPW>4): illegal=1 for the EXEC cycle, then behave as NOP (WB: ld_pc=1, pc_src=0, ld_ac=0).
REQ-031 Opcode 15 HLT: HALT held until reset; halted=1; all strobes 0.
REQ-032 Wait counter SHALL clear on each new access and increment per cycle while mem_ready=0.
REQ-033 When the wait counter reaches TIMEOUT without mem_ready: drop the request, set err=1, go to HALT.
REQ-034 mem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-035 rd_mem and wr_mem SHALL never be 1 together; ld_ir, ld_ac and ld_pc SHALL each be at most one-cycle pulses per access.
REQ-036 mem_ready outside FETCH/EXEC memory states SHALL be ignored.

Reset
REQ-037 rst_n=0 SHALL asynchronously force IDLE and set all outputs and the wait counter to 0, including err; it takes effect mid-access.
REQ-038 The first transition SHALL occur on the first rising clk edge after rst_n deasserts.

Structure
REQ-039 A shared package SHALL hold the state enum, the opcode constants (0-15) and the alu_op encodings.
REQ-040 The wait/timeout counter SHALL be one sub-module, mem_wait_timer (inputs clear, en; output expired).
REQ-041 Outputs SHALL be decoded from registered state plus latched opcode/ac_zero, with no combinational path from opcode.

Verification
REQ-042 start=1, opcode=0, mem_ready=1 after 2 cycles on each access -> sequence FETCH(3) DECODE EXEC(3) WB; ld_ac high 1 cycle; ld_pc/pc_src=0 in WB.
REQ-043 opcode=10, ac_zero=1 -> ld_pc=1, pc_src=1, jmp_uncond=0; repeat with ac_zero=0 -> pc_src=0.
REQ-044 mem_ready held 0 in FETCH, TIMEOUT=15 -> rd_mem drops after 15 cycles, err=1, halted=1; mem_ready on cycle 15 -> no error.
REQ-045 opcode=13 -> illegal pulses 1 cycle, ld_ac never asserted, PC incremented, returns to FETCH.
REQ-046 rst_n=0 mid-EXEC of STA -> wr_mem, err and halted go 0 immediately; IDLE after release.
REQ-047 opcode=15 -> halted=1 persists 100 cycles with start toggling; no strobes.
